// File: rtl/byte_decrypt_core_pkg.sv
// Shared types and helpers for the byte decryption core.
// Optional DEC_ROUND_DBG_EN exposes the live round index on round_dbg.
package byte_decrypt_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_ROUNDS = 8;
  localparam int ROT_W      = 3;

  function automatic logic [7:0] rotl8(
    input logic [7:0]       v,
    input logic [ROT_W-1:0] n
  );
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

endpackage

// File: rtl/byte_decrypt_core_inv_sbox.sv
// AES inverse S-box, pure combinational lookup.
// Shared by every decryption round of byte_decrypt_core.
module inv_sbox_lut (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5;
      8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
      8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e;
      8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
      8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82;
      8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
      8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44;
      8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
      8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32;
      8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
      8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b;
      8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
      8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66;
      8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
      8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49;
      8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
      8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64;
      8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
      8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc;
      8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
      8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50;
      8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
      8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57;
      8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
      8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00;
      8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
      8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05;
      8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
      8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
      8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03;
      8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
      8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41;
      8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
      8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce;
      8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22;
      8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
      8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8;
      8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
      8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71;
      8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
      8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e;
      8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
      8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b;
      8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
      8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe;
      8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
      8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33;
      8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
      8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59;
      8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
      8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9;
      8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
      8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f;
      8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
      8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d;
      8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
      8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c;
      8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
      8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e;
      8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
      8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63;
      8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
    endcase
  end

endmodule

// File: rtl/byte_decrypt_core.sv
// Iterative byte decryptor: one inverse round per cycle, valid/ready both sides.
// Define DEC_ROUND_DBG_EN to add the round_dbg output.
module byte_decrypt_core
  import byte_decrypt_core_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
`ifdef DEC_ROUND_DBG_EN
  ,
  output logic [3:0] round_dbg
`endif
);

  if (ROUNDS < 1 || ROUNDS > MAX_ROUNDS) begin : g_bad_rounds
    $error("byte_decrypt_core: ROUNDS must be 1..8");
  end

  localparam logic [ROT_W-1:0] LAST = ROT_W'(ROUNDS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [ROT_W-1:0] r_cnt;
  logic [7:0]       r_key;
  logic [7:0]       r_s;
  logic [7:0]       w_inv;
  logic [7:0]       w_rk;
  logic [7:0]       w_round;
  logic             w_acc;
  logic             w_last;

  assign w_acc   = in_valid && (r_state == IDLE);
  assign w_last  = (r_cnt == '0);
  assign w_rk    = rotl8(r_key, r_cnt);
  assign w_round = w_inv ^ w_rk;

  inv_sbox_lut u_inv (
    .i_byte (r_s),
    .o_byte (w_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc)     w_next = ROUND;
      ROUND:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
`ifdef DEC_ROUND_DBG_EN
    round_dbg = 4'hF;
    if (r_state == ROUND) round_dbg = {1'b0, r_cnt};
`endif
  end

  // r_s holds the ciphertext, then each intermediate, then the plaintext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= 8'h00;
      r_key <= 8'h00;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_s   <= in_data;
      r_key <= in_key;
      r_cnt <= LAST;
    end else if (r_state == ROUND) begin
      r_s <= w_round;
      if (!w_last) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign out_data = r_s;

endmodule

// File: tb/tb_byte_decrypt_core.sv
// Directed bench for byte_decrypt_core at ROUNDS = 1, 2 and 4.
// Covers latency, stalls, mid-round reset and a random round-trip.
module tb_byte_decrypt_core;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vin  [3];
  logic       rdy  [3];
  logic [7:0] din  [3];
  logic [7:0] kin  [3];
  logic       vout [3];
  logic       ordy [3];
  logic [7:0] dout [3];
`ifdef DEC_ROUND_DBG_EN
  logic [3:0] dbg  [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  byte_decrypt_core #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vin[0]), .in_ready(rdy[0]),
    .in_data(din[0]), .in_key(kin[0]),
    .out_valid(vout[0]), .out_ready(ordy[0]),
    .out_data(dout[0])
`ifdef DEC_ROUND_DBG_EN
    , .round_dbg(dbg[0])
`endif
  );

  byte_decrypt_core #(.ROUNDS(2)) u_r2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vin[1]), .in_ready(rdy[1]),
    .in_data(din[1]), .in_key(kin[1]),
    .out_valid(vout[1]), .out_ready(ordy[1]),
    .out_data(dout[1])
`ifdef DEC_ROUND_DBG_EN
    , .round_dbg(dbg[1])
`endif
  );

  byte_decrypt_core #(.ROUNDS(4)) u_r4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vin[2]), .in_ready(rdy[2]),
    .in_data(din[2]), .in_key(kin[2]),
    .out_valid(vout[2]), .out_ready(ordy[2]),
    .out_data(dout[2])
`ifdef DEC_ROUND_DBG_EN
    , .round_dbg(dbg[2])
`endif
  );

  task automatic chk(input logic [7:0] obs, input logic [7:0] exp,
                     input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v};
    return w[15-n -: 8];
  endfunction

  function automatic logic [7:0] enc4(input logic [7:0] p,
                                      input logic [7:0] k);
    logic [7:0] s;
    s = p;
    for (int r = 0; r < 4; r++) s = SBOX[s ^ rl(k, r)];
    return s;
  endfunction

  task automatic start(input int u, input logic [7:0] k,
                       input logic [7:0] d, input string tag);
    @(negedge clk);
    chk(8'(rdy[u]), 8'h01, {tag, "_in_ready"});
    vin[u] = 1'b1;
    din[u] = d;
    kin[u] = k;
    @(posedge clk);
    #1;
    vin[u] = 1'b0;
    din[u] = ~d;
    kin[u] = ~k;
  endtask

  // Entered #1 after the accepting edge
  task automatic finish_op(input int u, input logic [7:0] exp,
                           input int lat, input string tag);
    int n;
    n = 0;
    while (!vout[u] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(8'(n), 8'(lat), {tag, "_latency"});
    chk(dout[u], exp, {tag, "_data"});
    chk(8'(rdy[u]), 8'h00, {tag, "_busy_ready"});
    @(negedge clk);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    chk(8'(vout[u]), 8'h00, {tag, "_valid_drop"});
    chk(8'(rdy[u]), 8'h01, {tag, "_ready_back"});
  endtask

  task automatic decrypt(input int u, input logic [7:0] k,
                         input logic [7:0] d, input logic [7:0] exp,
                         input int lat, input string tag);
    start(u, k, d, tag);
    finish_op(u, exp, lat, tag);
  endtask

  initial begin
    logic [7:0] p, k;
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; din[i] = 8'h00; kin[i] = 8'h00; ordy[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(8'(vout[i]), 8'h00, $sformatf("rst_valid%0d", i));
      chk(dout[i], 8'h00, $sformatf("rst_data%0d", i));
    end
`ifdef DEC_ROUND_DBG_EN
    chk(8'(dbg[2]), 8'h0F, "rst_dbg");
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(8'(rdy[0]), 8'h01, "rel_ready");

    decrypt(0, 8'h00, 8'h63, 8'h00, 1, "r1_k00_63");
    decrypt(0, 8'h5A, 8'h63, 8'h5A, 1, "r1_k5a_63");
    decrypt(0, 8'h00, 8'h16, 8'hFF, 1, "r1_k00_16");
    decrypt(1, 8'h01, 8'hF3, 8'h00, 2, "r2_k01_f3");
    decrypt(2, 8'h00, 8'h0F, 8'h52, 4, "r4_k00_0f");

    // Output stall with spurious in_valid pulses
    start(2, 8'h00, 8'h76, "stall");
    n = 0;
    while (!vout[2] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(8'(n), 8'd4, "stall_latency");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vin[2] = i[0];
      din[2] = 8'hA5 + 8'(i);
      kin[2] = 8'h3C;
      chk(dout[2], 8'h00, "stall_data");
      chk(8'(vout[2]), 8'h01, "stall_valid");
      chk(8'(rdy[2]), 8'h00, "stall_ready");
    end
    @(negedge clk);
    vin[2] = 1'b0;
    ordy[2] = 1'b1;
    chk(dout[2], 8'h00, "stall_final_data");
    @(posedge clk);
    #1;
    ordy[2] = 1'b0;
    chk(8'(vout[2]), 8'h00, "stall_xfer_valid");
    chk(8'(rdy[2]), 8'h01, "stall_xfer_ready");
    @(posedge clk);
    #1;
    chk(8'(vout[2]), 8'h00, "stall_single_xfer");
    decrypt(2, 8'h00, 8'h0F, 8'h52, 4, "post_stall");

    // Reset in the middle of ROUND, then accept on the first edge
    start(2, 8'h00, 8'h76, "midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(8'(vout[2]), 8'h00, "midrst_valid");
    chk(dout[2], 8'h00, "midrst_data");
    vin[2] = 1'b1;
    din[2] = 8'h0F;
    kin[2] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(8'(rdy[2]), 8'h01, "midrst_rel_ready");
    @(posedge clk);
    #1;
    vin[2] = 1'b0;
    din[2] = 8'hEE;
    finish_op(2, 8'h52, 4, "midrst_next");

    for (int i = 0; i < 256; i++) begin
      p = 8'($urandom);
      k = 8'($urandom);
      decrypt(2, k, enc4(p, k), p, 4, $sformatf("rt%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
